// File: rtl/frame_decoder.sv
// Serial frame decoder: collects 14-bit frames MSB first, checks the embedded sync
// word, and presents {abc, def} downstream with valid/ready handshaking.
module frame_decoder #(
    parameter logic [11:0] SYNC    = 12'h345,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    output logic       o_bit_ready,
    output logic       o_abc,
    output logic       o_def,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_sync_err,
    output logic       o_timeout,
    output logic [7:0] o_frame_cnt,
    output logic [7:0] o_err_cnt
);

    // state | meaning
    // IDLE  | waiting for the first bit of a frame
    // SHIFT | collecting bits 12..0, gap timer running
    // HOLD  | decoded frame presented, waiting for i_ready
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] LAST_BIT = 4'd13;

    state_t      state, state_nxt;
    logic [13:0] frame, frame_nxt, frame_shift;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  gap_cnt, gap_cnt_nxt;
    logic        sync_err_nxt, timeout_nxt;
    logic        bit_take, xfer;

    assign bit_take    = i_bit_valid && (state != HOLD);
    assign xfer        = (state == HOLD) && i_ready;
    assign frame_shift = {frame[12:0], i_bit};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        frame_nxt    = frame;
        bit_cnt_nxt  = bit_cnt;
        gap_cnt_nxt  = gap_cnt;
        sync_err_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bit_take) begin
                    frame_nxt   = {13'd0, i_bit};
                    bit_cnt_nxt = 4'd1;
                    gap_cnt_nxt = 8'd0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_take) begin
                    frame_nxt   = frame_shift;
                    gap_cnt_nxt = 8'd0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = 4'd0;
                        if (frame_shift[12:1] == SYNC) begin
                            state_nxt = HOLD;
                        end else begin
                            state_nxt    = IDLE;
                            sync_err_nxt = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    // gap counter would reach TIMEOUT on this edge
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    bit_cnt_nxt = 4'd0;
                    gap_cnt_nxt = 8'd0;
                    frame_nxt   = 14'd0;
                end else begin
                    gap_cnt_nxt = gap_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            frame       <= 14'd0;
            bit_cnt     <= 4'd0;
            gap_cnt     <= 8'd0;
            o_sync_err  <= 1'b0;
            o_timeout   <= 1'b0;
            o_frame_cnt <= 8'd0;
            o_err_cnt   <= 8'd0;
        end else begin
            frame      <= frame_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            o_sync_err <= sync_err_nxt;
            o_timeout  <= timeout_nxt;
            if (xfer) o_frame_cnt <= o_frame_cnt + 8'd1;
            // error count moves together with its pulse and saturates
            if ((sync_err_nxt || timeout_nxt) && (o_err_cnt != 8'hFF))
                o_err_cnt <= o_err_cnt + 8'd1;
        end
    end

    assign o_valid     = (state == HOLD);
    assign o_bit_ready = (state != HOLD);
    assign o_abc       = o_valid && frame[13];
    assign o_def       = o_valid && frame[0];

endmodule

// File: tb/tb_frame_decoder.sv
// Directed self-checking bench for frame_decoder: good frames, backpressure,
// sync errors, gap timeout, reset handling and counter wrap/saturation.
module tb_frame_decoder;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_bit;
    logic       i_bit_valid;
    logic       o_bit_ready;
    logic       o_abc;
    logic       o_def;
    logic       o_valid;
    logic       i_ready;
    logic       o_sync_err;
    logic       o_timeout;
    logic [7:0] o_frame_cnt;
    logic [7:0] o_err_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_frames = 0;
    int exp_err    = 0;

    localparam logic [13:0] GOOD = 14'b1_0011_0100_0101_0;
    localparam logic [13:0] BAD  = {1'b0, 12'h344, 1'b1};

    frame_decoder dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .o_bit_ready (o_bit_ready),
        .o_abc       (o_abc),
        .o_def       (o_def),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sync_err  (o_sync_err),
        .o_timeout   (o_timeout),
        .o_frame_cnt (o_frame_cnt),
        .o_err_cnt   (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_bits(input logic [13:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            i_bit       = f[i];
            i_bit_valid = 1'b1;
            tick();
        end
        i_bit_valid = 1'b0;
        i_bit       = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n    = 1'b1;
        exp_frames = 0;
        exp_err    = 0;
    endtask

    task automatic test_reset();
        i_bit = 1'b0; i_bit_valid = 1'b0; i_ready = 1'b0;
        do_reset();
        checks++;
        if ({o_valid, o_abc, o_def, o_sync_err, o_timeout, o_bit_ready} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000001",
                     {o_valid, o_abc, o_def, o_sync_err, o_timeout, o_bit_ready});
        end
        checks++;
        if ({o_frame_cnt, o_err_cnt} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_counters: got %h/%h expected 00/00", o_frame_cnt, o_err_cnt);
        end
    endtask

    task automatic test_good_frame();
        i_ready = 1'b1;
        send_bits(GOOD, 13, 0);
        checks++;
        if ({o_valid, o_abc, o_def, o_bit_ready} !== 4'b1100) begin
            failures++;
            $display("FAIL good_out: got v/abc/def/rdy=%b expected 1100",
                     {o_valid, o_abc, o_def, o_bit_ready});
        end
        tick();
        exp_frames++;
        checks++;
        if (o_valid !== 1'b0 || o_frame_cnt !== 8'(exp_frames)) begin
            failures++;
            $display("FAIL good_xfer: got valid=%b cnt=%0d expected valid=0 cnt=%0d",
                     o_valid, o_frame_cnt, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        send_bits(GOOD, 13, 0);
        // offer bits while held; none may be consumed
        i_bit = 1'b1; i_bit_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({o_valid, o_abc, o_def, o_bit_ready} !== 4'b1100) begin
                failures++;
                $display("FAIL hold_cycle%0d: got v/abc/def/rdy=%b expected 1100", k,
                         {o_valid, o_abc, o_def, o_bit_ready});
            end
            if (k < 4) tick();
        end
        i_bit_valid = 1'b0; i_bit = 1'b0; i_ready = 1'b1;
        tick();
        exp_frames++;
        checks++;
        if (o_valid !== 1'b0 || o_bit_ready !== 1'b1 || o_frame_cnt !== 8'(exp_frames)) begin
            failures++;
            $display("FAIL hold_release: got valid=%b rdy=%b cnt=%0d expected 0/1/%0d",
                     o_valid, o_bit_ready, o_frame_cnt, exp_frames);
        end
        send_bits(GOOD, 13, 0);
        checks++;
        if ({o_valid, o_abc, o_def} !== 3'b110) begin
            failures++;
            $display("FAIL after_hold_frame: got v/abc/def=%b expected 110", {o_valid, o_abc, o_def});
        end
        tick();
        exp_frames++;
    endtask

    task automatic test_bad_sync();
        i_ready = 1'b1;
        send_bits(BAD, 13, 0);
        exp_err++;
        checks++;
        if (o_sync_err !== 1'b1 || o_valid !== 1'b0 || o_err_cnt !== 8'(exp_err)) begin
            failures++;
            $display("FAIL bad_sync: got err=%b valid=%b errcnt=%0d expected 1/0/%0d",
                     o_sync_err, o_valid, o_err_cnt, exp_err);
        end
        tick();
        checks++;
        if (o_sync_err !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_sync_pulse: got err=%b valid=%b expected 0/0", o_sync_err, o_valid);
        end
    endtask

    task automatic test_timeout();
        i_ready = 1'b1;
        send_bits(GOOD, 13, 9);
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (o_timeout !== (k == 16)) begin
                failures++;
                $display("FAIL timeout_gap%0d: got %b expected %b", k, o_timeout, k == 16);
            end
        end
        exp_err++;
        checks++;
        if (o_err_cnt !== 8'(exp_err) || o_bit_ready !== 1'b1 || o_sync_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_state: got errcnt=%0d rdy=%b serr=%b expected %0d/1/0",
                     o_err_cnt, o_bit_ready, o_sync_err, exp_err);
        end
        tick();
        checks++;
        if (o_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got %b expected 0", o_timeout);
        end
        send_bits(GOOD, 13, 0);
        checks++;
        if ({o_valid, o_abc, o_def} !== 3'b110) begin
            failures++;
            $display("FAIL after_timeout_frame: got v/abc/def=%b expected 110", {o_valid, o_abc, o_def});
        end
        tick();
        exp_frames++;
        // gap one short of the limit must be tolerated
        send_bits(GOOD, 13, 9);
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (o_timeout !== 1'b0) begin
                failures++;
                $display("FAIL gap15_cycle%0d: got timeout=%b expected 0", k, o_timeout);
            end
        end
        send_bits(GOOD, 8, 0);
        checks++;
        if ({o_valid, o_abc, o_def, o_timeout} !== 4'b1100 || o_err_cnt !== 8'(exp_err)) begin
            failures++;
            $display("FAIL gap15_frame: got v/abc/def/to=%b errcnt=%0d expected 1100/%0d",
                     {o_valid, o_abc, o_def, o_timeout}, o_err_cnt, exp_err);
        end
        tick();
        exp_frames++;
        checks++;
        if (o_frame_cnt !== 8'(exp_frames)) begin
            failures++;
            $display("FAIL gap15_cnt: got %0d expected %0d", o_frame_cnt, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        i_ready = 1'b1;
        send_bits(GOOD, 13, 7);
        do_reset();
        checks++;
        if ({o_valid, o_abc, o_def, o_sync_err, o_timeout, o_bit_ready} !== 6'b000001
            || o_frame_cnt !== 8'd0 || o_err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL midrst_out: got flags=%b cnt=%0d err=%0d expected 000001/0/0",
                     {o_valid, o_abc, o_def, o_sync_err, o_timeout, o_bit_ready}, o_frame_cnt, o_err_cnt);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (o_sync_err !== 1'b0 || o_timeout !== 1'b0) begin
                failures++;
                $display("FAIL midrst_pulse%0d: got serr=%b to=%b expected 0/0", k, o_sync_err, o_timeout);
            end
        end
        send_bits(GOOD, 13, 0);
        checks++;
        if ({o_valid, o_abc, o_def} !== 3'b110) begin
            failures++;
            $display("FAIL midrst_frame: got v/abc/def=%b expected 110", {o_valid, o_abc, o_def});
        end
        tick();
        exp_frames++;
        // reset while holding a frame drops it silently
        i_ready = 1'b0;
        send_bits(GOOD, 13, 0);
        do_reset();
        checks++;
        if (o_valid !== 1'b0 || o_sync_err !== 1'b0 || o_frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL holdrst: got valid=%b serr=%b cnt=%0d expected 0/0/0",
                     o_valid, o_sync_err, o_frame_cnt);
        end
        i_ready = 1'b1;
    endtask

    task automatic test_counters();
        do_reset();
        i_ready = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            send_bits(GOOD, 13, 0);
            tick();
            if (n == 255) begin
                checks++;
                if (o_frame_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL frame_cnt_255: got %0d expected 255", o_frame_cnt);
                end
            end
        end
        checks++;
        if (o_frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL frame_cnt_wrap: got %0d expected 0", o_frame_cnt);
        end
        for (int n = 1; n <= 300; n++) begin
            send_bits(BAD, 13, 0);
            tick();
            if (n == 254 || n == 255) begin
                checks++;
                if (o_err_cnt !== 8'(n)) begin
                    failures++;
                    $display("FAIL err_cnt_%0d: got %0d expected %0d", n, o_err_cnt, n);
                end
            end
        end
        checks++;
        if (o_err_cnt !== 8'd255 || o_frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL err_cnt_sat: got err=%0d frames=%0d expected 255/0", o_err_cnt, o_frame_cnt);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0; i_ready = 1'b0;
        tick();
        test_reset();
        test_good_frame();
        test_backpressure();
        test_bad_sync();
        test_timeout();
        test_reset_mid_frame();
        test_counters();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
